// File: rtl/sd_dat_rx_crc_pkg.sv
// sd_dat_rx_crc_pkg: shared SD DAT types, constants and the CRC16 step function
package sd_dat_rx_crc_pkg;
    typedef enum logic [1:0] {IDLE, DATA, CRC, ENDB} sd_state_t;
    localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;
    localparam int          SD_BLOCK_BYTES = 512;
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din, input logic [15:0] poly);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? poly : 16'h0000);
    endfunction
endpackage

// File: rtl/sd_dat_rx_crc_if.sv
// sd_dat_rx_crc_if: serial DAT0 input and sector-buffer/status outputs of the receive stage
interface sd_dat_rx_crc_if;
    logic        abort;
    logic        bit_en;
    logic        datain;
    logic [7:0]  rx_data;
    logic        rx_we;
    logic [11:0] rx_addr;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        frame_err;
    logic [15:0] crc_rx;
    modport master (output abort, bit_en, datain,
                    input  rx_data, rx_we, rx_addr, busy, done, crc_ok, frame_err, crc_rx);
    modport slave  (input  abort, bit_en, datain,
                    output rx_data, rx_we, rx_addr, busy, done, crc_ok, frame_err, crc_rx);
endinterface

// File: rtl/sd_dat_rx_crc_crc16_ser.sv
// sd_crc16_ser: bit-serial CRC16, shared between the RX and TX DAT paths
module sd_crc16_ser
    import sd_dat_rx_crc_pkg::*;
#(
    parameter logic [15:0] POLY = SD_CRC16_POLY,
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    // falling-edge CRC register: clear wins over a data bit
    always_ff @(negedge clk or negedge reset)
        if (!reset) crc <= INIT;
        else if (clr) crc <= INIT;
        else if (en) crc <= crc16_step(crc, din, POLY);
endmodule

// File: rtl/sd_dat_rx_crc.sv
// sd_dat_rx_crc: DAT0 packet receiver, byte assembly, CRC16 check and end-bit check
module sd_dat_rx_crc
    import sd_dat_rx_crc_pkg::*;
#(
    parameter int          BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter logic [15:0] CRC_POLY    = SD_CRC16_POLY,
    parameter logic [15:0] CRC_INIT    = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    sd_dat_rx_crc_if.slave    bus
);
    localparam logic [11:0] LAST = 12'(BLOCK_BYTES - 1);
    sd_state_t   state, state_nx;
    logic [2:0]  bitcnt;
    logic [11:0] bytecnt;
    logic [3:0]  crccnt;
    logic [6:0]  shift;
    logic [15:0] crc;
    logic        take, start, data_bit, crc_bit, end_bit;
    sd_crc16_ser #(.POLY(CRC_POLY), .INIT(CRC_INIT)) u_crc (
        .clk(clk), .reset(reset), .clr(start), .en(data_bit), .din(bus.datain), .crc(crc)
    );
    // state register, falling edge like the neighbouring DAT stages
    always_ff @(negedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    // next state: abort forces IDLE regardless of the strobe
    always_comb begin
        state_nx = state;
        if (bus.abort) state_nx = IDLE;
        else if (start) state_nx = DATA;
        else if (data_bit && bitcnt == 3'd0 && bytecnt == LAST) state_nx = CRC;
        else if (crc_bit && crccnt == 4'd0) state_nx = ENDB;
        else if (end_bit) state_nx = IDLE;
    end
    // per-state strobes; a low datain in IDLE is the start bit
    always_comb begin
        take     = bus.bit_en && !bus.abort;
        start    = take && state == IDLE && !bus.datain;
        data_bit = take && state == DATA;
        crc_bit  = take && state == CRC;
        end_bit  = take && state == ENDB;
        bus.busy = state != IDLE;
    end
    // counters, byte assembly, received CRC and status registers
    always_ff @(negedge clk or negedge reset)
        if (!reset) begin
            bitcnt        <= 3'd7;
            bytecnt       <= '0;
            crccnt        <= '0;
            shift         <= '0;
            bus.rx_data   <= '0;
            bus.rx_we     <= 1'b0;
            bus.rx_addr   <= '0;
            bus.done      <= 1'b0;
            bus.crc_ok    <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.crc_rx    <= '0;
        end else begin
            bus.rx_we <= 1'b0;
            bus.done  <= 1'b0;
            if (start) begin
                bitcnt        <= 3'd7;
                bytecnt       <= '0;
                bus.crc_ok    <= 1'b0;
                bus.frame_err <= 1'b0;
            end
            if (data_bit) begin
                shift  <= {shift[5:0], bus.datain};
                bitcnt <= bitcnt - 3'd1;
                if (bitcnt == 3'd0) begin
                    bus.rx_data <= {shift, bus.datain};
                    bus.rx_addr <= bytecnt;
                    bus.rx_we   <= 1'b1;
                    bytecnt     <= bytecnt + 12'd1;
                    crccnt      <= 4'd15;
                end
            end
            if (crc_bit) begin
                bus.crc_rx <= {bus.crc_rx[14:0], bus.datain};
                crccnt     <= crccnt - 4'd1;
            end
            if (end_bit) begin
                bus.frame_err <= !bus.datain;
                bus.crc_ok    <= bus.datain && crc == bus.crc_rx;
                bus.done      <= 1'b1;
            end
        end
endmodule

// File: tb/tb_sd_dat_rx_crc.sv
// tb_sd_dat_rx_crc: directed packet vectors plus abort/reset sequences for sd_dat_rx_crc
module tb_sd_dat_rx_crc;
    logic clk = 1'b0;
    logic reset = 1'b0;
    sd_dat_rx_crc_if bus();
    sd_dat_rx_crc dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] crc;
        logic        endb;
        bit          gaps;
        logic        exp_ok;
        logic        exp_ferr;
    } vec_t;
    vec_t vecs[5];

    int n_vec = 0, n_err = 0;
    int we_cnt, we_bad, done_cnt;
    logic [7:0] exp_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // one clock: drive after the rising edge, sample 1ns after the active falling edge
    task automatic tick(input logic en, input logic b, input logic ab);
        @(posedge clk);
        bus.bit_en = en; bus.datain = b; bus.abort = ab;
        @(negedge clk); #1;
        if (bus.rx_we) begin
            if (bus.rx_addr !== 12'(we_cnt) || bus.rx_data !== exp_byte) we_bad++;
            we_cnt++;
        end
        if (bus.done) done_cnt++;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 1)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic clear_mon(input logic [7:0] eb);
        we_cnt = 0; we_bad = 0; done_cnt = 0; exp_byte = eb;
    endtask

    task automatic send_body(input logic [7:0] d, input logic [15:0] c, input bit gaps);
        send_bit(1'b0, gaps);
        for (int k = 0; k < 512 * 8; k++) send_bit(d[7 - (k % 8)], gaps);
        for (int k = 0; k < 16; k++) send_bit(c[15 - k], gaps);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_mon(v.data);
        send_body(v.data, v.crc, v.gaps);
        check({tag, " no_early_done"}, done_cnt, 0);
        check({tag, " busy_before_end"}, bus.busy, 1);
        send_bit(v.endb, v.gaps);
        check({tag, " done_pulse"}, bus.done, 1);
        check({tag, " crc_ok"}, bus.crc_ok, v.exp_ok);
        check({tag, " frame_err"}, bus.frame_err, v.exp_ferr);
        check({tag, " crc_rx"}, bus.crc_rx, v.crc);
        check({tag, " we_count"}, we_cnt, 512);
        check({tag, " we_addr_data"}, we_bad, 0);
        tick(1'b0, 1'b1, 1'b0);
        check({tag, " done_one_cycle"}, bus.done, 0);
        check({tag, " idle_after"}, bus.busy, 0);
        check({tag, " crc_ok_held"}, bus.crc_ok, v.exp_ok);
    endtask

    initial begin
        bus.bit_en = 1'b0; bus.datain = 1'b1; bus.abort = 1'b0;
        vecs[0] = '{8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 16'h7FA1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 16'h7FA0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 16'h7FA1, 1'b1, 1'b1, 1'b1, 1'b0};
        #12;
        check("rst rx_data", bus.rx_data, 0);
        check("rst rx_we", bus.rx_we, 0);
        check("rst rx_addr", bus.rx_addr, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst crc_ok", bus.crc_ok, 0);
        check("rst frame_err", bus.frame_err, 0);
        check("rst crc_rx", bus.crc_rx, 0);
        @(posedge clk); reset = 1'b1;
        clear_mon(8'h00);
        repeat (4) tick(1'b1, 1'b1, 1'b0);
        check("idle high ignored", bus.busy, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // abort on bit 3 of byte 100 together with a strobe
        clear_mon(8'h00);
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < 100 * 8 + 4; k++) send_bit(1'b0, 1'b0);
        check("abort pre busy", bus.busy, 1);
        check("abort pre we_count", we_cnt, 100);
        tick(1'b1, 1'b0, 1'b1);
        check("abort busy", bus.busy, 0);
        check("abort rx_we", bus.rx_we, 0);
        for (int k = 0; k < 24; k++) tick(1'b1, 1'b1, 1'b0);
        check("abort no more we", we_cnt, 100);
        check("abort no done", done_cnt, 0);
        check("abort crc_ok held", bus.crc_ok, 0);
        check("abort frame_err held", bus.frame_err, 0);
        tick(1'b0, 1'b1, 1'b0);
        run_vec(vecs[1], "post_abort");

        // abort coinciding with the end bit suppresses done and keeps status
        clear_mon(8'h00);
        send_body(8'h00, 16'h0000, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check("endb abort done", bus.done, 0);
        check("endb abort busy", bus.busy, 0);
        check("endb abort crc_ok", bus.crc_ok, 0);
        tick(1'b1, 1'b1, 1'b0);
        check("endb abort no late done", done_cnt, 0);

        // asynchronous reset mid-packet
        clear_mon(8'hFF);
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) send_bit(1'b1, 1'b0);
        check("pre reset rx_data", bus.rx_data, 8'hFF);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check("mid rst rx_data", bus.rx_data, 0);
        check("mid rst rx_addr", bus.rx_addr, 0);
        check("mid rst busy", bus.busy, 0);
        check("mid rst crc_rx", bus.crc_rx, 0);
        @(posedge clk); reset = 1'b1; bus.bit_en = 1'b0; bus.datain = 1'b1;
        run_vec(vecs[0], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
